line_burst_bridge: RTL

- Memory-side responder for the cache's line interface.
- Accepts whole-line read and write requests from the cache (line address, 256-bit line) and completes them as 4-beat 64-bit bursts on the physical memory port.
- Returns a single-cycle response to the cache when the line transfer finishes.
- Sits between the cache line port and the main memory model or arbiter.

---
 rtl/cache_types.sv | 15 +
 rtl/line_shift_buffer.sv | 32 +++
 rtl/line_burst_bridge.sv | 100 ++++++++++
 3 files changed

// File: rtl/cache_types.sv
// Shared cache-side types and sizing constants.
// Used by the line bridge and its buffer.
package cache_types;
  localparam int S_LINE = 256;
  localparam int S_BURST = 64;
  localparam int S_OFFSET = 5;
  localparam int BEATS_PER_LINE = S_LINE / S_BURST;

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    DONE
  } bridge_state_t;
endpackage

// File: rtl/line_shift_buffer.sv
// Line buffer with whole-line load and beat-indexed
// write and read ports.
module line_shift_buffer #(
  parameter int line_w = 256,
  parameter int beat_w = 64,
  parameter int idx_w = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [line_w-1:0] load_line,
  input  logic              beat_we,
  input  logic [idx_w-1:0]  beat_idx,
  input  logic [beat_w-1:0] beat_in,
  output logic [line_w-1:0] line,
  output logic [beat_w-1:0] beat_out
);
  logic [line_w-1:0] data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data <= '0;
    end else if (load) begin
      data <= load_line;
    end else if (beat_we) begin
      data[beat_idx*beat_w +: beat_w] <= beat_in;
    end
  end

  assign line = data;
  assign beat_out = data[beat_idx*beat_w +: beat_w];
endmodule

// File: rtl/line_burst_bridge.sv
// Cache line port to 4-beat memory burst bridge.
// One request at a time; single-cycle resp_o on finish.
module line_burst_bridge
  import cache_types::*;
#(
  parameter int s_line = S_LINE,
  parameter int s_burst = S_BURST,
  parameter int s_offset = S_OFFSET
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);
  localparam int num_beats = s_line / s_burst;
  localparam int cw = $clog2(num_beats);
  localparam logic [cw-1:0] last_idx = cw'(num_beats - 1);

  bridge_state_t state, state_nx;
  logic [cw-1:0] count, count_nx;
  logic [31-s_offset:0] addr;
  logic load, beat_we, take;
  logic [s_burst-1:0] beat;

  assign take = (state == IDLE) && (write_i || read_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      addr <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      if (take) addr <= address_i[31:s_offset];
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    load = 1'b0;
    beat_we = 1'b0;
    unique case (state)
      IDLE: begin
        if (write_i) begin
          load = 1'b1;
          state_nx = WR_BURST;
        end else if (read_i) begin
          state_nx = RD_BURST;
        end
      end
      RD_BURST, WR_BURST: begin
        if (resp_i) begin
          beat_we = (state == RD_BURST);
          if (count == last_idx) begin
            count_nx = '0;
            state_nx = DONE;
          end else begin
            count_nx = count + 1'b1;
          end
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  line_shift_buffer #(
    .line_w(s_line),
    .beat_w(s_burst),
    .idx_w(cw)
  ) u_buf (
    .clk(clk),
    .rst(rst),
    .load(load),
    .load_line(line_i),
    .beat_we(beat_we),
    .beat_idx(count),
    .beat_in(burst_i),
    .line(line_o),
    .beat_out(beat)
  );

  assign read_o = (state == RD_BURST);
  assign write_o = (state == WR_BURST);
  assign resp_o = (state == DONE);
  assign address_o = {addr, {s_offset{1'b0}}};
  assign burst_o = write_o ? beat : '0;
endmodule
